// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) constant multipliers over 0x11B and the FSM state type.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] a);
        mul2 = xtime(a);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] a);
        mul3 = xtime(a) ^ a;
    endfunction

    // 9, 11, 13 and 14 are built from x^3, x^2 and x terms plus the identity.
    function automatic logic [7:0] mul9(input logic [7:0] a);
        mul9 = xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] a);
        mul11 = xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] a);
        mul13 = xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] a);
        mul14 = xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

endpackage

// File: rtl/mix_column.sv
// Combinational MixColumns on one 32-bit column (row 0 in the MSB byte).
// With MIXCOL_INV_EN defined, input inv selects InvMixColumns.
module mix_column
    import aes_pkg::*;
(
`ifdef MIXCOL_INV_EN
    input  logic        inv,
`endif
    input  logic [31:0] col,
    output logic [31:0] res
);

    logic [7:0] a0_s, a1_s, a2_s, a3_s;

    assign a0_s = col[31:24];
    assign a1_s = col[23:16];
    assign a2_s = col[15:8];
    assign a3_s = col[7:0];

    // Column transform; coefficient rows rotate by one byte per output row.
    always_comb begin
        res = 32'h0000_0000;
`ifdef MIXCOL_INV_EN
        if (inv) begin
            res = {mul14(a0_s) ^ mul11(a1_s) ^ mul13(a2_s) ^ mul9(a3_s),
                   mul9(a0_s)  ^ mul14(a1_s) ^ mul11(a2_s) ^ mul13(a3_s),
                   mul13(a0_s) ^ mul9(a1_s)  ^ mul14(a2_s) ^ mul11(a3_s),
                   mul11(a0_s) ^ mul13(a1_s) ^ mul9(a2_s)  ^ mul14(a3_s)};
        end else begin
            res = {mul2(a0_s) ^ mul3(a1_s) ^ a2_s ^ a3_s,
                   a0_s ^ mul2(a1_s) ^ mul3(a2_s) ^ a3_s,
                   a0_s ^ a1_s ^ mul2(a2_s) ^ mul3(a3_s),
                   mul3(a0_s) ^ a1_s ^ a2_s ^ mul2(a3_s)};
        end
`else
        res = {mul2(a0_s) ^ mul3(a1_s) ^ a2_s ^ a3_s,
               a0_s ^ mul2(a1_s) ^ mul3(a2_s) ^ a3_s,
               a0_s ^ a1_s ^ mul2(a2_s) ^ mul3(a3_s),
               mul3(a0_s) ^ a1_s ^ a2_s ^ mul2(a3_s)};
`endif
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: COLS_PER_CYCLE columns per BUSY cycle, valid/ready on both sides.
// Optional feature macro MIXCOL_INV_EN adds the inv port and the InvMixColumns datapath.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
`ifdef MIXCOL_INV_EN
    input  logic         inv,
`endif
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    mc_state_e          state_r, state_nxt_s;
    logic [2:0]         cnt_r, cnt_nxt_s;
    logic [0:3][31:0]   work_r, work_nxt_s;
    logic               in_ready_r, out_valid_r;
    logic [1:0]         col_idx_s [COLS_PER_CYCLE];
    logic [31:0]        col_out_s [COLS_PER_CYCLE];
`ifdef MIXCOL_INV_EN
    logic               inv_r;
`endif

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign col_idx_s[k] = cnt_r[1:0] + 2'(k);
        mix_column u_mix_column (
`ifdef MIXCOL_INV_EN
            .inv (inv_r),
`endif
            .col (work_r[col_idx_s[k]]),
            .res (col_out_s[k])
        );
    end

    // Next-state, counter and working-register update. Once the counter hits 4
    // the block spends one more BUSY cycle before DONE, giving 4/N+1 edges of latency.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        work_nxt_s  = work_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    work_nxt_s  = in_state;
                    cnt_nxt_s   = 3'd0;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 3'd4) begin
                    state_nxt_s = DONE;
                end else begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                        work_nxt_s[col_idx_s[k]] = col_out_s[k];
                    end
                    cnt_nxt_s = cnt_r + STEP;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            work_r      <= 128'h0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            work_r      <= work_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

`ifdef MIXCOL_INV_EN
    // Mode is captured with the block so it cannot change mid-transform.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_r <= 1'b0;
        end else if ((state_r == IDLE) && in_valid) begin
            inv_r <= inv;
        end else begin
            inv_r <= inv_r;
        end
    end
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_state = work_r;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed self-checking bench: three DUTs (1, 2 and 4 columns per cycle) run the same stimulus.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
    logic         inv;
    logic         in_ready1, in_ready2, in_ready4;
    logic         out_valid1, out_valid2, out_valid4;
    logic [127:0] out_state1, out_state2, out_state4;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
`ifdef MIXCOL_INV_EN
        .inv(inv),
`endif
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_state(in_state), .out_valid(out_valid1), .out_ready(out_ready),
        .out_state(out_state1));

    mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
`ifdef MIXCOL_INV_EN
        .inv(inv),
`endif
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_state(in_state), .out_valid(out_valid2), .out_ready(out_ready),
        .out_state(out_state2));

    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
`ifdef MIXCOL_INV_EN
        .inv(inv),
`endif
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_state(in_state), .out_valid(out_valid4), .out_ready(out_ready),
        .out_state(out_state4));

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Send one block, check latency of each DUT, hold-off behaviour, then release it.
    task automatic run_block(input logic [127:0] din, input logic mode, input string tag,
                             output logic [127:0] res1, output logic [127:0] res2,
                             output logic [127:0] res4);
        int lat1 = 0, lat2 = 0, lat4 = 0;
        logic [127:0] hold;
        logic stable = 1'b1;
        @(negedge clk);
        in_state = din;
        inv      = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_state = ~din;
        inv      = ~mode;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (e == 2) in_valid = 1'b0;
            if (lat1 == 0 && out_valid1) lat1 = e;
            if (lat2 == 0 && out_valid2) lat2 = e;
            if (lat4 == 0 && out_valid4) lat4 = e;
        end
        check_val({tag, "_lat1"}, 128'(lat1), 128'd5);
        check_val({tag, "_lat2"}, 128'(lat2), 128'd3);
        check_val({tag, "_lat4"}, 128'(lat4), 128'd2);
        hold = out_state1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_state1 !== hold || in_ready1 !== 1'b0 || out_valid1 !== 1'b1) stable = 1'b0;
        end
        check_val({tag, "_hold"}, 128'(stable), 128'd1);
        res1 = out_state1;
        res2 = out_state2;
        res4 = out_state4;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_rdy"}, {125'd0, in_ready1, in_ready2, in_ready4}, 128'd7);
        check_val({tag, "_vld"}, {125'd0, out_valid1, out_valid2, out_valid4}, 128'd0);
    endtask

    logic [127:0] vin  [5];
    logic [127:0] vexp [5];
    logic [127:0] r1, r2, r4, f1, f2, f4;

    initial begin
        vin[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        vexp[0] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        vin[1] = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
        vexp[1] = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
        vin[2] = 128'h80000000_000000ff_00000000_00000000;
        vexp[2] = 128'h1b80809b_ffff1ae5_00000000_00000000;
        vin[3] = 128'h00000000_00000000_00000000_00000000;
        vexp[3] = 128'h00000000_00000000_00000000_00000000;
        vin[4] = 128'h00000000_00000000_00000000_d4d4d4d5;
        vexp[4] = 128'h00000000_00000000_00000000_d5d5d7d6;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = 128'h0;
        inv       = 1'b0;
        #12;
        check_val("rst_vld", {125'd0, out_valid1, out_valid2, out_valid4}, 128'd0);
        check_val("rst_state", out_state1 | out_state2 | out_state4, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_rdy", {125'd0, in_ready1, in_ready2, in_ready4}, 128'd7);

        for (int i = 0; i < 5; i++) begin
            run_block(vin[i], 1'b0, $sformatf("fwd%0d", i), r1, r2, r4);
            check_val($sformatf("fwd%0d_c1", i), r1, vexp[i]);
            check_val($sformatf("fwd%0d_c2", i), r2, vexp[i]);
            check_val($sformatf("fwd%0d_c4", i), r4, vexp[i]);
        end

        // Reset during the second BUSY cycle.
        @(negedge clk);
        in_state = vin[0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_vld", {125'd0, out_valid1, out_valid2, out_valid4}, 128'd0);
        check_val("mid_rst_state", out_state1 | out_state2 | out_state4, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("mid_rst_rdy", {125'd0, in_ready1, in_ready2, in_ready4}, 128'd7);
        run_block({4{32'h01010101}}, 1'b0, "post_rst", r1, r2, r4);
        check_val("post_rst_c1", r1, {4{32'h01010101}});
        check_val("post_rst_c2", r2, {4{32'h01010101}});
        check_val("post_rst_c4", r4, {4{32'h01010101}});

`ifdef MIXCOL_INV_EN
        run_block(vexp[0], 1'b1, "inv0", r1, r2, r4);
        check_val("inv0_c1", r1, vin[0]);
        check_val("inv0_c2", r2, vin[0]);
        check_val("inv0_c4", r4, vin[0]);
        for (int t = 0; t < 3; t++) begin
            logic [127:0] rnd;
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run_block(rnd, 1'b0, $sformatf("rt%0d_f", t), f1, f2, f4);
            run_block(f1, 1'b1, $sformatf("rt%0d_i", t), r1, r2, r4);
            check_val($sformatf("rt%0d_c1", t), r1, rnd);
            check_val($sformatf("rt%0d_f24", t), f2 ^ f4, 128'h0);
            check_val($sformatf("rt%0d_c4", t), r4, rnd);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1: number of columns transformed per BUSY cycle; legal values are 1, 2 and 4.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  in_state holds a valid block.
REQ-005 in_ready  output  1  block can accept a new input.
REQ-006 in_state  input  128  AES state; column c = bits [127-32c -: 32]; row 0 is the MSB byte of each column.
REQ-007 out_valid  output  1  out_state holds a result.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 out_state  output  128  transformed state, same byte layout as in_state.
REQ-010 inv  input  1  selects InvMixColumns; this port exists only when MIXCOL_INV_EN is defined (see REQ-024).

Function
REQ-011 Forward transform per column (a0..a3 -> r0..r3), all arithmetic in GF(2^8) with polynomial 0x11B:
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
REQ-012 Multiplication by 2 (xtime) = left shift by one, XOR 0x1B when the shifted-out bit was 1; multiplication by 3 = xtime(a)^a; all results are 8 bits.
REQ-013 The FSM has three states: IDLE, BUSY and DONE.
REQ-014 in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE with in_valid=1: load in_state into the working register, clear the column counter, and go to BUSY.
REQ-016 In each BUSY cycle, transform columns counter..counter+COLS_PER_CYCLE-1 in place, then advance the counter by COLS_PER_CYCLE.
REQ-017 When the last column has been written, go to DONE.
REQ-018 Latency: out_valid rises exactly 4/COLS_PER_CYCLE+1 rising edges after the accepting edge (5 edges for the default).
REQ-019 In DONE, out_state stays stable while out_ready=0; on out_valid&&out_ready the FSM goes to IDLE, with no same-cycle accept of new input.
REQ-020 in_state and in_valid changes during BUSY or DONE are ignored.
REQ-021 out_state is driven from the working register; its value outside DONE is don't-care for consumers, but it never shows X after reset.

Reset
REQ-022 When rst_n=0, immediately force:
  - state = IDLE
  - column counter = 0
  - working register = 128'h0
  - out_valid = 0
  - in_ready = 1 once rst_n=1
REQ-023 Reset during BUSY or DONE discards the block in progress; the first post-reset acceptance behaves as a fresh start.

Configuration
REQ-024 With MIXCOL_INV_EN defined:
  - port inv is present and is sampled and held at acceptance.
  - inv=1 applies InvMixColumns with coefficient rows {0e,0b,0d,09} rotated per row.
  - inv=0 applies the forward transform.
  - latency is identical for both modes.
REQ-025 Without MIXCOL_INV_EN, port inv is absent and only the forward transform is built.

Structure
REQ-026 The shared package aes_pkg holds:
  - the xtime function and the GF multiply-by-constant helpers (2, 3, 9, 11, 13, 14)
  - the AES polynomial constant 8'h1B
  - the FSM state typedef
REQ-027 One combinational sub-module, mix_column, transforms a single 32-bit column (with the inv input under MIXCOL_INV_EN) and is instantiated COLS_PER_CYCLE times.

Verification
REQ-028 Forward transform: in_state=db135345_f20a225c_01010101_c6c6c6c6 -> out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-029 Second forward vector: column d4d4d4d5 -> d5d5d7d6 and column 2d26314c -> 4d7ebdf8.
REQ-030 Handshake: hold out_ready=0 for 10 cycles after out_valid; out_state must stay unchanged and in_ready must stay 0. Then pulse out_ready=1 -> in_ready=1 on the next cycle.
REQ-031 Latency sweep: with COLS_PER_CYCLE = 1, 2 and 4, out_valid must rise 5, 3 and 2 edges after acceptance respectively, and results must match REQ-028.
REQ-032 Mid-operation reset: assert rst_n=0 during the second BUSY cycle -> out_valid=0 immediately; next block 01010101 x4 -> result 01010101 x4.
REQ-033 With MIXCOL_INV_EN and inv=1, input 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> output db135345_f20a225c_01010101_c6c6c6c6; back-to-back forward/inverse round trips on random states must return the original state.
